de_morgan_verifier: RTL and testbench
=====================================

# de_morgan_verifier

Sequential self-checking harness stage for the De Morgan gate exercises. It sits directly upstream and downstream of the combinational gate: it drives the `a`/`b` inputs through all four input combinations, samples the gate's `y`, and compares `y` against the expected first-law value `~(a & b)`. It reports an error count and a pass/done flag, so lab boards and benches get a single go/no-go result in place of manual waveform inspection.

## Interface
- `HOLD_CYCLES`, default 4: clock cycles each input vector is held. Legal values are 2 or more.
- `ERR_W`, default 3: width of the error counter.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begins a check run; sampled on `clk`.
- `y`  input  1  output of the gate under test.
- `a`  output  1  gate input A, registered.
- `b`  output  1  gate input B, registered.
- `vec_idx`  output  2  index of the current vector; `a = vec_idx[1]`, `b = vec_idx[0]`.
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  high once a run completes; held until the next accepted `start` or reset.
- `pass`  output  1  valid when `done=1`; equals `err_cnt == 0`.
- `err_cnt`  output  ERR_W  number of mismatches in the current or last run; saturates at all-ones.

## Operation
- States:
  - IDLE: entered from reset.
  - DRIVE: vectors applied in order 0,1,2,3 (ab = 00, 01, 10, 11).
  - DONE: reached after vector 3 is checked.
- Hold counter `cnt` runs from 0 to `HOLD_CYCLES-1` for each vector.
- Transitions:
  - IDLE or DONE, `start=1`:
    - go to DRIVE with `vec_idx=0` and `cnt=0`.
    - clear `err_cnt`, `done` and `pass`.
  - DRIVE, `cnt < HOLD_CYCLES-1`: increment `cnt`.
  - DRIVE, `cnt == HOLD_CYCLES-1`:
    - compare `y` against `~(a & b)`; on mismatch, `err_cnt` increments, saturating at `2^ERR_W - 1`.
    - if `vec_idx == 3`, go to DONE.
    - otherwise increment `vec_idx` and reset `cnt` to 0.
  - Entering DONE: `done=1`, `pass = (final err_cnt == 0)`, `busy=0`.
    - `pass` includes the vector-3 result, computed combinationally from the updated count.
- `start` while in DRIVE is ignored; no restart and no counter change.
- Output levels by state:
  - `busy=1` only in DRIVE.
  - In IDLE and DONE, `a`, `b` and `vec_idx` return to 0.
  - `err_cnt` holds its value in DONE.
- `y` is treated as combinational from `a`/`b`. Sampling only at the last hold cycle masks gate settle time.

## Timing
- Reset (asynchronous, any state, including mid-run):
  - state goes to IDLE.
  - `a`, `b`, `vec_idx`, `busy`, `done`, `pass` and `err_cnt` all go to 0 immediately.
  - the first accepted `start` is the first rising edge after `rst_n` deasserts.
- With `start` accepted at edge E0:
  - vector k is driven from edge E0 + k·H to edge E0 + (k+1)·H, where H = `HOLD_CYCLES`.
  - `y` for vector k is sampled at edge E0 + (k+1)·H.
- `done`/`pass` rise at edge E0 + 4·H; latency is 16 cycles at the default H.
- Back-to-back runs: `start` high in the first DONE cycle restarts at the next edge with zero dead cycles.
- `err_cnt` changes only on a sampling edge or a restart.

## Test plan
- Reset:
  - Stimulus: `rst_n=0` for 3 cycles with `start` toggling.
  - Required: all outputs 0 and state IDLE; `busy` stays 0.
- Correct gate:
  - Stimulus: `y = ~a | ~b`, H=4, `start` pulse at cycle 0.
  - Required: `a`/`b` step 00→01→10→11 every 4 cycles; `done=1` at cycle 16; `err_cnt=0`; `pass=1`.
- Faulty gates, ERR_W=3:
  - `y` stuck at 0 → `err_cnt=3`, `pass=0`.
  - `y` stuck at 1 → `err_cnt=1`.
  - `y = a & b` → `err_cnt=4`.
- Saturation:
  - Stimulus: ERR_W=2, `y = a & b`.
  - Required: `err_cnt` steps 1, 2, 3, 3 and finishes at 3; `pass=0`.
- Start while busy:
  - Stimulus: a second `start` pulse at cycle 6 of a run.
  - Required: ignored; `done` still at cycle 16 and `vec_idx` sequence unchanged.
- Reset mid-run and restart:
  - Stimulus: `rst_n` low at cycle 9, released at cycle 11, `start` at cycle 12.
  - Required: outputs 0 during reset; a full clean run follows with `done` at cycle 28 for the correct gate, `pass=1`.

Source files
------------

// File: rtl/de_morgan_verifier.sv
// Self-checking harness for a De Morgan gate: walks ab through 00..11,
// samples y on the last hold cycle and counts mismatches against ~(a & b).
module de_morgan_verifier #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;

  logic             last_hold;
  logic             mism;
  logic [ERR_W-1:0] err_inc;

  assign last_hold = (cnt_q == CNT_LAST);
  assign mism      = y ^ ~(vec_q[1] & vec_q[0]);
  assign err_inc   = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          vec_d   = 2'd0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (!last_hold) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (mism) err_d = err_inc;
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
            vec_d   = 2'd0;
            // pass folds in the vector-3 result just computed
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        vec_d   = 2'd0;
        err_d   = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign a       = vec_q[1];
  assign b       = vec_q[0];
  assign vec_idx = vec_q;
  assign busy    = (state_q == S_DRIVE);
  assign done    = (state_q == S_DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_de_morgan_verifier.sv
// Bench for de_morgan_verifier: one ERR_W=3 and one ERR_W=2 instance
// fed by the same selectable gate model.
module tb_de_morgan_verifier;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;

  logic       a1, b1, y1, busy1, done1, pass1;
  logic [1:0] v1;
  logic [2:0] e1;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic [1:0] v2;
  logic [1:0] e2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic gate(input logic [1:0] m, input logic x,
                                input logic z);
    case (m)
      2'd0:    gate = ~x | ~z;
      2'd1:    gate = 1'b0;
      2'd2:    gate = 1'b1;
      default: gate = x & z;
    endcase
  endfunction

  assign y1 = gate(mode, a1, b1);
  assign y2 = gate(mode, a2, b2);

  de_morgan_verifier #(.HOLD_CYCLES(H), .ERR_W(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y1),
    .a(a1), .b(b1), .vec_idx(v1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(e1)
  );

  de_morgan_verifier #(.HOLD_CYCLES(H), .ERR_W(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y2),
    .a(a2), .b(b2), .vec_idx(v2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(e2)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] mask;
    int         err3;
    int         err2;
    logic       pass;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " a"}, int'(a1), 0);
    chk({tag, " b"}, int'(b1), 0);
    chk({tag, " vec"}, int'(v1), 0);
    chk({tag, " busy"}, int'(busy1), 0);
    chk({tag, " done"}, int'(done1), 0);
    chk({tag, " pass"}, int'(pass1), 0);
    chk({tag, " err"}, int'(e1), 0);
    chk({tag, " busy2"}, int'(busy2), 0);
    chk({tag, " err2"}, int'(e2), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Entered #1 after the accepting edge; returns #1 after edge +4H.
  task automatic run_body(input logic [3:0] mask, input int err3,
                          input int err2, input logic ps,
                          input int kick_at, input int stop_at);
    int k, n;
    for (int c = 0; c < 4 * H; c++) begin
      if (c == stop_at) return;
      k = c / H;
      n = 0;
      for (int j = 0; j < k; j++) if (mask[j]) n++;
      chk("run vec", int'(v1), k);
      chk("run a", int'(a1), k / 2);
      chk("run b", int'(b1), k % 2);
      chk("run busy", int'(busy1), 1);
      chk("run done", int'(done1), 0);
      chk("run err", int'(e1), (n > 7) ? 7 : n);
      chk("run vec2", int'(v2), k);
      chk("run err2", int'(e2), (n > 3) ? 3 : n);
      if (c == kick_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("end done", int'(done1), 1);
    chk("end busy", int'(busy1), 0);
    chk("end vec", int'(v1), 0);
    chk("end a", int'(a1), 0);
    chk("end b", int'(b1), 0);
    chk("end err", int'(e1), err3);
    chk("end pass", int'(pass1), int'(ps));
    chk("end done2", int'(done2), 1);
    chk("end err2", int'(e2), err2);
    chk("end pass2", int'(pass2), (err2 == 0) ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mode: 2'd0, mask: 4'b0000, err3: 0, err2: 0, pass: 1'b1};
    tbl[1] = '{mode: 2'd1, mask: 4'b0111, err3: 3, err2: 3, pass: 1'b0};
    tbl[2] = '{mode: 2'd2, mask: 4'b1000, err3: 1, err2: 1, pass: 1'b0};
    tbl[3] = '{mode: 2'd3, mask: 4'b1111, err3: 4, err2: 3, pass: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    #1;
    check_zero("rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start = ~start;
      check_zero("rst hold");
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("idle");

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      pulse_start();
      run_body(tbl[i].mask, tbl[i].err3, tbl[i].err2, tbl[i].pass, -1, 99);
      @(posedge clk);
      #1;
      chk("hold done", int'(done1), 1);
      chk("hold err", int'(e1), tbl[i].err3);
      chk("hold pass", int'(pass1), int'(tbl[i].pass));
    end

    // second start at cycle 6 must be ignored
    mode = 2'd0;
    pulse_start();
    run_body(4'b0000, 0, 0, 1'b1, 6, 99);

    // back-to-back: faulty run, then restart in first DONE cycle
    mode = 2'd3;
    pulse_start();
    run_body(4'b1111, 4, 3, 1'b0, -1, 99);
    mode = 2'd0;
    pulse_start();
    run_body(4'b0000, 0, 0, 1'b1, -1, 99);

    // reset mid-run, then a clean run
    @(posedge clk);
    #1;
    pulse_start();
    run_body(4'b0000, 0, 0, 1'b1, -1, 9);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst1");
    @(posedge clk);
    #1;
    check_zero("midrst2");
    rst_n = 1'b1;
    pulse_start();
    run_body(4'b0000, 0, 0, 1'b1, -1, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
